// File: rtl/req_sync_arbiter.sv
// req_sync_arbiter: round-robin arbiter for NUM_REQ asynchronous four-phase
//   requesters sharing one resource. Every request passes through a private
//   SYNC_STAGES-deep synchronizer before the FSM (IDLE -> GRANT -> WAIT_REQ_LOW) sees it.
// Latency: grant/ack rise SYNC_STAGES edges after a request is first captured;
//   ack falls SYNC_STAGES+1 edges after the request falls (synchronizer plus FSM edge).
// Backpressure: a requester holds req until ack; the owner releases the grant with a
//   one-cycle done pulse; the next grant waits until the owner's request has gone low.
// Ports:
//   clk          single clock
//   reset        synchronous active-high reset
//   req_async    per-requester request, asynchronous to clk
//   ack          per-requester acknowledge (registered)
//   grant        one-hot ownership (registered); grant_valid = OR(grant)
//   grant_id     index of the current/last owner, held while grant_valid is low
//   done         one-cycle release pulse from the owner, used only in GRANT
//   timeout      one-cycle pulse on a forced release
// Optional: define ARB_TIMEOUT_EN to build a grant watchdog that force-releases the
//   grant after TIMEOUT_CYCLES GRANT cycles without done. Without it timeout is 0.
module req_sync_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_async,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  input  logic                       done,
  output logic                       timeout
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT_REQ_LOW
  } state_t;

  state_t           state;
  logic [IDW-1:0]   last_winner;
  logic [NUM_REQ-1:0] req_s;
  logic [IDW-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_oh;

  // Private synchronizer per requester; only the last stage is ever used.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain;
    always_ff @(posedge clk) begin
      if (reset) begin
        chain <= '0;
      end else begin
        chain <= {chain[SYNC_STAGES-2:0], req_async[i]};
      end
    end
    assign req_s[i] = chain[SYNC_STAGES-1];
  end

  // Round-robin search starting at last+1. Walking the offsets from the far end
  // down to 1 lets the nearest requesting index overwrite the others.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDW-1:0]     last);
    logic [IDW-1:0] w;
    int             idx;
    w   = '0;
    idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (r[IDW'(idx)]) w = IDW'(idx);
    end
    return w;
  endfunction

  assign pick_idx    = rr_pick(req_s, last_winner);
  assign pick_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
  assign grant_valid = |grant;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ack         <= '0;
      grant       <= '0;
      grant_id    <= '0;
      last_winner <= IDW'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      to_cnt      <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req_s) begin
            grant       <= pick_oh;
            ack         <= pick_oh;
            grant_id    <= pick_idx;
            last_winner <= pick_idx;
            state       <= GRANT;
`ifdef ARB_TIMEOUT_EN
            to_cnt      <= '0;
`endif
          end
        end
        GRANT: begin
          // The owner's request level is deliberately not looked at here: a
          // request that drops early still keeps the grant until released.
          if (done) begin
            grant <= '0;
            state <= WAIT_REQ_LOW;
`ifdef ARB_TIMEOUT_EN
          end else if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            grant   <= '0;
            timeout <= 1'b1;
            state   <= WAIT_REQ_LOW;
          end else begin
            to_cnt <= to_cnt + CW'(1);
`endif
          end
        end
        WAIT_REQ_LOW: begin
          if (!req_s[grant_id]) begin
            ack   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
